keypad_scan: RTL and testbench

Scans a 4x4 active-low matrix keypad, debounces the press and release of one key, and produces a 4-bit key code with a held-level `pressed` flag. It sits directly upstream of the counting front end: `key` and `pressed` feed the counter FSM's `key`/`pressed` inputs, alongside the push-button path. It has one clock domain. The row inputs are asynchronous and are synchronised internally.

---
 rtl/keypad_pkg.sv | 19 +
 rtl/keypad_debounce.sv | 28 ++
 rtl/keypad_scan.sv | 153 +++++++++++++++
 tb/tb_keypad_scan.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, the
// row/column-to-code map and the "no row pulled low" pattern.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} state_t;

  localparam logic [3:0] NO_ROW = 4'hF;

  // Indexed by {row, col}: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = E 0 F D.
  localparam logic [15:0][3:0] CODE_MAP = 64'hDF0E_C987_B654_A321;

  // Lowest-index low bit wins when several rows in one column are pressed.
  function automatic logic [1:0] first_low(input logic [3:0] r);
    first_low = 2'd3;
    for (int i = 3; i >= 0; i--)
      if (!r[i]) first_low = 2'(i);
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Stability counter shared by press and release debouncing. The FSM clears it
// on entry to a debounce state and leaves that state on any level change.
module keypad_debounce #(
  parameter int DEB_CYCLES = 200000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic level_n,
  output logic stable_low,
  output logic stable_high
);
  localparam int CW = $clog2(DEB_CYCLES);

  logic [CW-1:0] cnt;
  logic          at_end;

  assign at_end      = (cnt == CW'(DEB_CYCLES - 1));
  assign stable_low  = at_end & ~level_n;
  assign stable_high = at_end & level_n;

  always_ff @(posedge clk) begin
    if (!rst_n)       cnt <= '0;
    else if (clr)     cnt <= '0;
    else if (!at_end) cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner with press/release debounce.
// Optional auto-repeat of key_valid while held: define KEYPAD_REPEAT_EN.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV      = 1000,
  parameter int DEB_CYCLES    = 200000,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 20000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       pressed,
  output logic       key_valid
);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_t        state, state_n;
  logic [3:0]    row_m, row_s;
  logic [1:0]    col_idx, col_idx_n, row_idx, row_idx_n;
  logic [DW-1:0] dwell, dwell_n;
  logic [3:0]    key_n;
  logic          pressed_n, kv_n;
  logic          level_n, stable_low, stable_high;

  assign col     = ~(4'b0001 << col_idx);
  assign level_n = row_s[row_idx];

  keypad_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        ((state == SCAN) || (state == HELD)),
    .level_n    (level_n),
    .stable_low (stable_low),
    .stable_high(stable_high)
  );

`ifdef KEYPAD_REPEAT_EN
  logic [31:0] rep_cnt, rep_cnt_n, rep_lim;
  logic        rep_first, rep_first_n;
  assign rep_lim = rep_first ? 32'(REPEAT_DELAY - 1) : 32'(REPEAT_PERIOD - 1);
`else
  logic unused_rep;
  assign unused_rep = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_m     <= NO_ROW;
      row_s     <= NO_ROW;
      state     <= SCAN;
      col_idx   <= '0;
      row_idx   <= '0;
      dwell     <= '0;
      key       <= 4'h0;
      pressed   <= 1'b0;
      key_valid <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= '0;
      rep_first <= 1'b1;
`endif
    end else begin
      row_m     <= row;
      row_s     <= row_m;
      state     <= state_n;
      col_idx   <= col_idx_n;
      row_idx   <= row_idx_n;
      dwell     <= dwell_n;
      key       <= key_n;
      pressed   <= pressed_n;
      key_valid <= kv_n;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= rep_cnt_n;
      rep_first <= rep_first_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    col_idx_n = col_idx;
    row_idx_n = row_idx;
    dwell_n   = dwell;
    key_n     = key;
    pressed_n = pressed;
    kv_n      = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_n   = rep_cnt;
    rep_first_n = rep_first;
`endif
    case (state)
      SCAN: begin
        if (dwell == DW'(SCAN_DIV - 1)) begin
          dwell_n = '0;
          if (row_s == NO_ROW) begin
            col_idx_n = col_idx + 2'd1;
          end else begin
            row_idx_n = first_low(row_s);
            state_n   = DEB_PRESS;
          end
        end else begin
          dwell_n = dwell + DW'(1);
        end
      end
      DEB_PRESS: begin
        if (level_n) begin
          state_n = SCAN;
        end else if (stable_low) begin
          state_n   = HELD;
          key_n     = CODE_MAP[{row_idx, col_idx}];
          pressed_n = 1'b1;
          kv_n      = 1'b1;
`ifdef KEYPAD_REPEAT_EN
          rep_cnt_n   = '0;
          rep_first_n = 1'b1;
`endif
        end
      end
      HELD: begin
        if (level_n) state_n = DEB_REL;
`ifdef KEYPAD_REPEAT_EN
        if (rep_cnt != rep_lim) begin
          rep_cnt_n = rep_cnt + 32'd1;
        end else if (!level_n) begin
          kv_n        = 1'b1;
          rep_cnt_n   = '0;
          rep_first_n = 1'b0;
        end
`endif
      end
      DEB_REL: begin
`ifdef KEYPAD_REPEAT_EN
        // Keeps running across a bounce; parks at the limit so the due
        // repeat fires once the key is seen held again.
        if (rep_cnt != rep_lim) rep_cnt_n = rep_cnt + 32'd1;
`endif
        if (!level_n) begin
          state_n = HELD;
        end else if (stable_high) begin
          state_n   = SCAN;
          pressed_n = 1'b0;
          col_idx_n = col_idx + 2'd1;
          dwell_n   = '0;
        end
      end
      default: state_n = SCAN;
    endcase
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Scoreboard bench for keypad_scan: a key matrix model drives row from col,
// expected codes are queued at press time and checked on each key_valid.
module tb_keypad_scan;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row, col, key;
  logic       pressed, key_valid;
  logic [15:0] keys = '0;   // index row*4+col

  always #5 clk = ~clk;

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  keypad_scan #(
    .SCAN_DIV(4), .DEB_CYCLES(8), .REPEAT_DELAY(20), .REPEAT_PERIOD(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col),
    .key(key), .pressed(pressed), .key_valid(key_valid)
  );

  int vectors = 0, miscompares = 0;
  int cyc = 0, acc_cnt = 0, acc_t = 0;
  int rep_t[$];
  logic [3:0] exp_q[$];
  logic [3:0] exp_key;
  logic prev_kv = 1'b0, prev_pressed = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // key_valid monitor: accepts pop the scoreboard, repeats are timestamped.
  always @(negedge clk) begin
    if (rst_n && key_valid) begin
      chk("kv_1cyc", prev_kv, 0);
      if (prev_pressed) begin
`ifdef KEYPAD_REPEAT_EN
        rep_t.push_back(cyc);
        chk("rep_key", key, exp_key);
`else
        chk("kv_repeat", prev_pressed, 0);
`endif
      end else begin
        chk("kv_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_key = exp_q.pop_front();
          chk("key", key, exp_key);
          chk("kv_pressed", pressed, 1);
          acc_cnt++;
          acc_t = cyc;
        end
      end
    end
    prev_kv      <= key_valid;
    prev_pressed <= pressed;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_change(output int dt);
    logic [3:0] c0;
    c0 = col;
    dt = 0;
    while (col == c0 && dt < 50) begin
      @(negedge clk);
      dt++;
    end
    chk("col_change_tmo", col != c0, 1);
  endtask

  task automatic wait_col(input logic [3:0] target);
    logic [3:0] last;
    int n;
    last = col;
    n = 0;
    while (!(col == target && last != target) && n < 50) begin
      last = col;
      @(negedge clk);
      n++;
    end
    chk("wait_col_tmo", col, target);
  endtask

  task automatic wait_acc(input int a0);
    int n;
    n = 0;
    while (acc_cnt == a0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("acc_tmo", acc_cnt != a0, 1);
  endtask

  initial begin
    logic [3:0] seq [4];
    int dt, a0;
    seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

    // Reset state and free-running column scan
    cycles(3);
    chk("rst_col", col, 4'b1110);
    chk("rst_key", key, 4'h0);
    chk("rst_pressed", pressed, 0);
    chk("rst_kv", key_valid, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_change(dt);
      chk("scan_col", col, seq[i]);
      if (i > 0) chk("scan_dwell", dt, 4);
    end

    // Clean press of '5' (row1, col1)
    exp_q.push_back(4'h5);
    a0 = acc_cnt;
    keys[5] = 1'b1;
    cycles(40);
    chk("p5_key", key, 4'h5);
    chk("p5_pressed", pressed, 1);
    chk("p5_accepts", acc_cnt - a0, 1);
    keys = '0;
    cycles(3);
    chk("p5_rel_deb", pressed, 1);
    cycles(12);
    chk("p5_released", pressed, 0);
    chk("p5_key_hold", key, 4'h5);

    // Short glitch on '5' during press debounce
    wait_col(4'b1101);
    keys[5] = 1'b1;
    cycles(6);
    chk("gl_frozen", col, 4'b1101);
    keys = '0;
    cycles(4);
    chk("gl_same_col", col, 4'b1101);
    chk("gl_pressed", pressed, 0);
    wait_change(dt);
    chk("gl_next_col", col, 4'b1011);
    chk("gl_key", key, 4'h5);

    // Rows 0 and 2 in column 0: lowest row wins
    exp_q.push_back(4'h1);
    keys[0] = 1'b1;
    keys[8] = 1'b1;
    cycles(40);
    chk("two_key", key, 4'h1);
    chk("two_pressed", pressed, 1);
    keys = '0;
    cycles(15);
    chk("two_released", pressed, 0);

    // Release bounce on '9' (row2, col2)
    exp_q.push_back(4'h9);
    keys[10] = 1'b1;
    cycles(40);
    a0 = acc_cnt;
    keys = '0;
    cycles(3);
    keys[10] = 1'b1;
    cycles(12);
    chk("bnc_pressed", pressed, 1);
    chk("bnc_no_kv", acc_cnt - a0, 0);
    chk("bnc_key", key, 4'h9);
    keys = '0;
    cycles(15);
    chk("bnc_released", pressed, 0);

`ifdef KEYPAD_REPEAT_EN
    // Auto-repeat on held '0' (row3, col1)
    exp_q.push_back(4'h0);
    a0 = acc_cnt;
    keys[13] = 1'b1;
    wait_acc(a0);
    rep_t.delete();
    cycles(45);
    chk("rep_count", rep_t.size() >= 3, 1);
    if (rep_t.size() >= 3) begin
      chk("rep_first", rep_t[0] - acc_t, 20);
      chk("rep_second", rep_t[1] - acc_t, 30);
      chk("rep_third", rep_t[2] - acc_t, 40);
    end
    keys = '0;
    cycles(15);
`endif

    // Reset while a key ('F', row3 col2) is held
    exp_q.push_back(4'hF);
    a0 = acc_cnt;
    keys[14] = 1'b1;
    wait_acc(a0);
    cycles(2);
    chk("mid_pressed", pressed, 1);
    rst_n = 1'b0;
    keys = '0;
    @(negedge clk);
    chk("mid_rst_col", col, 4'b1110);
    chk("mid_rst_key", key, 4'h0);
    chk("mid_rst_pressed", pressed, 0);
    chk("mid_rst_kv", key_valid, 0);
    rst_n = 1'b1;
    cycles(30);
    chk("post_rst_pressed", pressed, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
